// File: rtl/pe_row_collector.sv
// pe_row_collector: captures one column edge of PE outputs after a sort
// completes and streams the words downstream over a valid/ready handshake,
// optionally flagging any accepted key that is smaller than its predecessor.
module pe_row_collector #(
    parameter int N           = 4,
    parameter int DATA_WIDTH  = 3,
    parameter bit CHECK_ORDER = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N*2*DATA_WIDTH-1:0]   i_PE,
    input  logic                        i_sort_done,
    output logic [2*DATA_WIDTH-1:0]     o_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_order_err
);

    localparam int W  = 2 * DATA_WIDTH;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [W-1:0]          r_buf [N];
    logic [IW-1:0]         r_idx;
    logic [DATA_WIDTH-1:0] r_prev_key;
    logic                  r_done;
    logic                  r_err;

    logic                  w_xfer;
    logic                  w_last;
    logic [W-1:0]          w_word;
    logic [DATA_WIDTH-1:0] w_key;

    // Single-entry buffer needs no index select
    generate
        if (N == 1) begin : g_single
            assign w_word = r_buf[0];
        end else begin : g_multi
            assign w_word = r_buf[r_idx];
        end
    endgenerate

    assign w_key  = w_word[DATA_WIDTH-1:0];
    assign w_xfer = (r_state == DRAIN) && i_ready;
    assign w_last = (r_idx == LAST);

    assign o_valid     = (r_state == DRAIN);
    assign o_data      = (r_state == DRAIN) ? w_word : '0;
    assign o_busy      = (r_state != IDLE);
    assign o_done      = r_done;
    assign o_order_err = r_err;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (i_sort_done) w_state_nxt = CAPTURE;
            CAPTURE: w_state_nxt = DRAIN;
            DRAIN:   if (w_xfer && w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Read index, done pulse and order tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_prev_key <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= w_xfer && w_last;
            if (r_state == CAPTURE) begin
                r_idx <= '0;
                r_err <= 1'b0;
            end else if (w_xfer) begin
                r_prev_key <= w_key;
                if (!w_last) begin
                    r_idx <= r_idx + IW'(1);
                end
                if (CHECK_ORDER && (r_idx != '0) && (w_key < r_prev_key)) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Word buffer: loaded only from IDLE, so a drain in progress is never disturbed
    always_ff @(posedge clk) begin
        if ((r_state == IDLE) && i_sort_done) begin
            for (int unsigned k = 0; k < N; k++) begin
                r_buf[k] <= i_PE[k*W +: W];
            end
        end
    end

endmodule
